// File: rtl/mod_sram_arbiter_if.sv
// Requester, SRAM-controller and status signals of mod_sram_arbiter.
// slave = arbiter view, master = environment (requesters + controller) view.
interface mod_sram_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_data;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_data;

    logic        v_req;
    logic [31:0] v_addr;
    logic        v_ack;
    logic [31:0] v_data;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_rdy;

    logic        busy;
    logic [1:0]  grant;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, v_req, v_addr,
               m_rdata, m_rdy,
        output i_ack, i_data, d_ack, d_data, v_ack, v_data,
               m_req, m_we, m_addr, m_wdata, busy, grant
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, v_req, v_addr,
               m_rdata, m_rdy,
        input  i_ack, i_data, d_ack, d_data, v_ack, v_data,
               m_req, m_we, m_addr, m_wdata, busy, grant
    );
endinterface

// File: rtl/mod_sram_arbiter.sv
// Three-way SRAM request arbiter (D > I > V) with VGA aging override.
// Optional macro ARB_PMC_EN adds pmc_arb_conflict / pmc_vga_starve pulses.
module mod_sram_arbiter #(
    parameter int unsigned VGA_MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    mod_sram_arbiter_if.slave bus
`ifdef ARB_PMC_EN
    ,
    output logic              pmc_arb_conflict,
    output logic              pmc_vga_starve
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G_I    = 2'b01;
    localparam logic [1:0] G_D    = 2'b10;
    localparam logic [1:0] G_V    = 2'b11;
    localparam logic [7:0] AGE_MAX = 8'(VGA_MAX_WAIT);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  owner;
    logic [1:0]  sel;
    logic [7:0]  age;
    logic        v_aged;
    logic        selecting;

    assign v_aged    = bus.v_req && (age == AGE_MAX);
    assign selecting = (state == IDLE) && (sel != G_NONE);

    always_comb begin
        sel = G_NONE;
        if (v_aged)
            sel = G_V;
        else if (bus.d_req)
            sel = G_D;
        else if (bus.i_req)
            sel = G_I;
        else if (bus.v_req)
            sel = G_V;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel != G_NONE) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (bus.m_rdy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.m_req = (state == ISSUE);
        bus.busy  = (state != IDLE);
        bus.grant = owner;
        bus.i_ack = (state == DONE) && (owner == G_I);
        bus.d_ack = (state == DONE) && (owner == G_D);
        bus.v_ack = (state == DONE) && (owner == G_V);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= G_NONE;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.i_data  <= '0;
            bus.d_data  <= '0;
            bus.v_data  <= '0;
        end else begin
            state <= state_nx;
            if (selecting) begin
                owner       <= sel;
                bus.m_we    <= (sel == G_D) && bus.d_we;
                bus.m_wdata <= (sel == G_D) ? bus.d_wdata : '0;
                case (sel)
                    G_D:     bus.m_addr <= bus.d_addr;
                    G_I:     bus.m_addr <= bus.i_addr;
                    default: bus.m_addr <= bus.v_addr;
                endcase
            end
            if (state == WAIT && bus.m_rdy) begin
                case (owner)
                    G_I:     bus.i_data <= bus.m_rdata;
                    G_D:     bus.d_data <= bus.m_we ? '0 : bus.m_rdata;
                    G_V:     bus.v_data <= bus.m_rdata;
                    default: ;
                endcase
            end
            if (state == DONE)
                owner <= G_NONE;
        end
    end

    // Age counts V's pending time under any other owner; selection of V or a dropped req clears it.
    always_ff @(posedge clk) begin
        if (!rst)
            age <= '0;
        else if (selecting && sel == G_V)
            age <= '0;
        else if (!bus.v_req)
            age <= '0;
        else if (owner != G_V && age < AGE_MAX)
            age <= age + 8'd1;
    end

`ifdef ARB_PMC_EN
    logic multi_req;
    assign multi_req = (bus.i_req & bus.d_req) | (bus.i_req & bus.v_req) | (bus.d_req & bus.v_req);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pmc_arb_conflict <= 1'b0;
            pmc_vga_starve   <= 1'b0;
        end else begin
            pmc_arb_conflict <= selecting && multi_req;
            pmc_vga_starve   <= (state == IDLE) && v_aged;
        end
    end
`endif
endmodule

// File: doc/mod_sram_arbiter.md
Name: mod_sram_arbiter

Overview:
- Shares the single request port of the SRAM controller between three requesters: instruction-fill (I), data fill/write-through (D) and VGA framebuffer reads (V).
- Sits between the memory hierarchy, the VGA fetch logic and the SRAM controller.
- Uses fixed priority D > I > V, with an aging override so V is never starved.
- Serializes accesses and returns a one-cycle ack to each requester with its read data.

Parameters:
- VGA_MAX_WAIT, 16: cycles V may wait with a pending request before it is granted ahead of D and I. Range 1..255.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- i_req  in  1  instruction-fill request, held until i_ack
- i_addr  in  32  instruction byte address
- i_ack  out  1  one-cycle pulse, i_data valid
- i_data  out  32  instruction read data
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle pulse
- d_data  out  32  read data; 0 on write ack
- v_req  in  1  VGA read request, held until v_ack
- v_addr  in  32  VGA byte address
- v_ack  out  1  one-cycle pulse
- v_data  out  32  VGA read data
- m_req  out  1  one-cycle issue strobe to SRAM controller
- m_we  out  1  write enable for the issued access
- m_addr  out  32  registered address
- m_wdata  out  32  registered write data
- m_rdata  in  32  controller read data, valid with m_rdy
- m_rdy  in  1  controller completion pulse
- busy  out  1  state != IDLE
- grant  out  2  current owner: 00 none, 01 I, 10 D, 11 V

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all acks, m_req, m_we, busy = 0; grant=00.
  - m_addr, m_wdata, i_data, d_data, v_data = 0; age counter = 0.
  - Reset mid-access abandons the access; no ack is issued. The controller is reset by the same rst.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: sample requests. If V aged (age == VGA_MAX_WAIT and v_req), pick V. Otherwise pick D, else I, else V.
  - IDLE with a selection: latch grant, m_addr, m_we (d_we for D, else 0) and m_wdata (d_wdata for D, else 0); go to ISSUE. With no request, stay in IDLE.
  - ISSUE: m_req=1 for exactly this cycle; go to WAIT.
  - WAIT: hold until m_rdy=1. On m_rdy, latch m_rdata into the granted requester's data register (0 for a D write); go to DONE.
  - DONE: pulse the granted ack for one cycle; grant returns to 00 on the next edge; go to IDLE.
- Latency:
  - Request visible at edge N gives m_req at N+1.
  - If m_rdy arrives at N+2, the ack is at N+3.
  - Minimum back-to-back issue spacing is 4 cycles.
- Requester rules:
  - Address and data must stay stable from req until ack.
  - req still high in the cycle after ack is treated as a new request.
  - Data registers hold their value until that requester's next ack.
- m_rdy outside WAIT is ignored.
- Aging counter (8 bit):
  - Increments each cycle v_req=1 while grant != 11.
  - Saturates at VGA_MAX_WAIT.
  - Clears when V is selected or when v_req=0.
- Simultaneous events:
  - All three requesting with V not aged: order D, I, V.
  - V aged while D and I are pending: V is served first.
  - A request arriving while busy waits for IDLE; no preemption.

Optional Feature:
- ARB_PMC_EN defined adds two output ports:
  - pmc_arb_conflict: one-cycle pulse on an IDLE selection made while two or more reqs are high.
  - pmc_vga_starve: one-cycle pulse when V is selected through the aging override.
  - Both are 0 in reset.
- ARB_PMC_EN undefined: these ports and their logic do not exist; the block is otherwise identical.

Test Plan:
- Single I read: i_req, i_addr=0x100, controller returns m_rdata=0xCAFEF00D two cycles after m_req -> m_req once with m_addr=0x100, m_we=0; i_ack one pulse 3 cycles after m_req; i_data=0xCAFEF00D.
- D write: d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678; d_ack pulse; d_data=0.
- Simultaneous I, D, V with VGA_MAX_WAIT=16 -> service order D, I, V; exactly one ack each; grant sequence 10, 01, 11.
- Starvation: D and I re-request continuously, v_req held -> V is served by the first IDLE after age reaches 16; pmc_vga_starve pulses if ARB_PMC_EN is defined.
- Reset during WAIT: rst=0 for one edge -> state IDLE, no ack, busy=0, grant=00; a later m_rdy is ignored.
- m_rdy delayed 20 cycles -> busy held and m_req not repeated; ack follows m_rdy by exactly 1 cycle.
